// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch stage with prefetch queue and redirect flush
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [AW-1:0] im_addr_o,
  input  logic [DW-1:0] im_data_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_addr_i,
  input  logic          ir_ready_i,
  output logic          ir_valid_o,
  output logic [DW-1:0] ir_o,
  output logic [AW-1:0] ir_pc_o,
  output logic [CW-1:0] count_o
);

  logic [AW+DW-1:0] entry_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic             push, pop;

  assign ir_valid_o = (count_q != '0);
  assign pop        = ir_valid_o & ir_ready_i;
  // A pop frees a slot in the same cycle, so a full queue can still accept a word.
  assign push       = ~redirect_i & ((count_q < CW'(DEPTH)) | pop);

  assign im_addr_o  = fetch_pc_q;
  assign count_o    = count_q;
  assign ir_o       = ir_valid_o ? entry_q[rd_ptr_q][DW-1:0]     : '0;
  assign ir_pc_o    = ir_valid_o ? entry_q[rd_ptr_q][AW+DW-1:DW] : '0;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      // The head handshake (if any) still completes; the rest of the queue is discarded.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_addr_i;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_q[wr_ptr_q] <= {fetch_pc_q, im_data_i};
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - scoreboard bench for ifetch_queue
module tb_ifetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] im_addr_o;
  logic [31:0] im_data_i;
  logic        redirect_i;
  logic [15:0] redirect_addr_i;
  logic        ir_ready_i;
  logic        ir_valid_o;
  logic [31:0] ir_o;
  logic [15:0] ir_pc_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  assign im_data_i = 32'h1000_0000 + {16'h0, im_addr_o};

  ifetch_queue dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .im_addr_o       (im_addr_o),
    .im_data_i       (im_data_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .ir_ready_i      (ir_ready_i),
    .ir_valid_o      (ir_valid_o),
    .ir_o            (ir_o),
    .ir_pc_o         (ir_pc_o),
    .count_o         (count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(input logic [15:0] start);
    logic [15:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(pc);
      pc = pc + 16'd1;
    end
  endtask

  // Sample at the falling edge; a valid&ready pair here is the handshake of the next rising edge.
  task automatic cycle();
    logic [15:0] e;
    @(negedge clk_i);
    if (ir_valid_o && ir_ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {16'h0, ir_pc_o}, {16'h0, e});
        check("sb_ir", ir_o, 32'h1000_0000 + {16'h0, e});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [15:0] held;
    rst_i = 1'b1;
    redirect_i = 1'b0;
    redirect_addr_i = 16'h0;
    ir_ready_i = 1'b1;
    cycle();
    cycle();
    check("rst_valid", ir_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_addr", im_addr_o, 0);
    check("rst_ir", ir_o, 0);
    check("rst_irpc", ir_pc_o, 0);

    // streaming with ir_ready held high
    sb_restart(16'h0);
    rst_i = 1'b0;
    cycle();
    check("first_valid", ir_valid_o, 1);
    check("first_pc", ir_pc_o, 0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("stream_count", count_o, 1);
    end

    // back-pressure from reset: fill, freeze, then drain without gap
    rst_i = 1'b1;
    ir_ready_i = 1'b0;
    cycle();
    sb_restart(16'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("fill_count", count_o, (i < 3) ? i + 1 : 4);
      check("fill_addr", im_addr_o, (i < 3) ? i + 1 : 4);
    end
    ir_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("full_pp_count", count_o, 4);
    end
    ir_ready_i = 1'b0;
    held = im_addr_o;
    check("full_addr", im_addr_o, 12);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_count", count_o, 4);
      check("stall_addr", im_addr_o, held);
    end

    // redirect while holding PCs 5..8, head consumed in the redirect cycle
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0005;
    cycle();
    sb_restart(16'h0005);
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("q58_count", count_o, 4);
    check("q58_head", ir_pc_o, 5);
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0040;
    ir_ready_i = 1'b1;
    cycle();
    sb_restart(16'h0040);
    redirect_i = 1'b0;
    check("redir_valid", ir_valid_o, 0);
    check("redir_count", count_o, 0);
    cycle();
    check("redir_valid2", ir_valid_o, 1);
    check("redir_pc", ir_pc_o, 16'h0040);
    for (int i = 0; i < 4; i++) cycle();

    // fetch PC wraps through 0xFFFF
    redirect_i = 1'b1;
    redirect_addr_i = 16'hFFFE;
    cycle();
    sb_restart(16'hFFFE);
    redirect_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("wrap_count", count_o, 1);
    end
    check("wrap_left", exp_q.size(), 64 - 5);

    // asynchronous reset between edges with three entries queued
    ir_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0100;
    cycle();
    sb_restart(16'h0100);
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("pre_rst_count", count_o, 3);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_valid", ir_valid_o, 0);
    check("arst_count", count_o, 0);
    check("arst_addr", im_addr_o, 0);
    check("arst_ir", ir_o, 0);
    @(posedge clk_i);
    #1;
    sb_restart(16'h0);
    rst_i = 1'b0;
    ir_ready_i = 1'b1;
    cycle();
    check("resume_pc", ir_pc_o, 0);
    for (int i = 0; i < 5; i++) cycle();
    check("resume_left", exp_q.size(), 64 - 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
